// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared widths, FSM states and port index type for the RAM port arbiter
package ram_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - two-way round-robin grant: a lone request wins, a tie goes to the port not granted last
module ram_rr_arbiter
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == PORT1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-port RAM between an instruction port (0) and a data port (1)
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_drive,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_t             port_q, port_d;
  port_t             last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        gnt;
  logic              in_access;
  logic              in_done;

  ram_rr_arbiter u_rr (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      port_q   <= PORT0;
      last_q   <= PORT1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          port_d  = gnt[1] ? PORT1 : PORT0;
          last_d  = gnt[1] ? PORT1 : PORT0;
          we_d    = gnt[1] ? we1 : we0;
          addr_d  = gnt[1] ? addr1 : addr0;
          wdata_d = gnt[1] ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        // Compare with <= so a zero count can never underflow.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          if (!we_q) begin
            if (port_q == PORT1) rdata1_d = ram_rdata;
            else                 rdata0_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs are gated by state so nothing leaks outside ACCESS.
  always_comb begin
    in_access        = (state_q == ACCESS);
    in_done          = (state_q == DONE);
    ram_address      = in_access ? addr_q : '0;
    ram_read_enable  = in_access && !we_q;
    ram_write_enable = in_access && we_q;
    ram_drive        = in_access && we_q;
    ram_wdata        = (in_access && we_q) ? wdata_q : '0;
    ack0             = in_done && (port_q == PORT0);
    ack1             = in_done && (port_q == PORT1);
    busy             = (state_q != IDLE);
    rdata0           = rdata0_q;
    rdata1           = rdata1_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed table, tie/reset/hold sequences and random traffic against a transaction model
module tb_ram_port_arbiter;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, ram_write_enable, ram_read_enable, ram_drive, busy;
  logic [7:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [3:0] ram_address;

  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.ACCESS_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_write_enable(ram_write_enable),
    .ram_read_enable(ram_read_enable), .ram_wdata(ram_wdata),
    .ram_drive(ram_drive), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_address];
  always @(posedge clk) if (ram_write_enable) mem[ram_address] <= ram_wdata;

  wire [33:0] outs = {ack0, ack1, rdata0, rdata1, ram_address, ram_write_enable,
                      ram_read_enable, ram_wdata, ram_drive, busy};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((ram_read_enable && ram_write_enable) || (ack0 && ack1)) begin
        errors++;
        $display("FAIL exclusive: re=%b we=%b ack0=%b ack1=%b required not both", ram_read_enable,
                 ram_write_enable, ack0, ack1);
      end
    end
  end

  task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] a,
                          input logic [7:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 20 && busy; t++) @(negedge clk);
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_access(input string nm, input int p, input logic w, input logic [3:0] a,
                           input logic [7:0] d);
    int lat, wcnt, rcnt;
    logic bus_ok;
    wait_idle();
    set_port(p, 1'b1, w, a, d);
    lat = 0; wcnt = 0; rcnt = 0; bus_ok = 1'b1;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (ram_write_enable) begin
        wcnt++;
        if (!ram_drive || ram_wdata !== d || ram_address !== a) bus_ok = 1'b0;
      end
      if (ram_read_enable) begin
        rcnt++;
        if (ram_address !== a || ram_drive) bus_ok = 1'b0;
      end
      if ((p == 0) ? ack0 : ack1) lat = k;
    end
    set_port(p, 1'b0, 1'b0, 4'd0, 8'd0);
    check({nm, "_ack_cycle"}, lat, N + 1);
    check({nm, "_wr_cycles"}, wcnt, w ? N : 0);
    check({nm, "_rd_cycles"}, rcnt, w ? 0 : N);
    check({nm, "_bus"}, bus_ok, 1'b1);
  endtask

  task automatic tie_test(input string nm, input int first);
    int a0c, a1c;
    wait_idle();
    set_port(0, 1'b1, 1'b0, 4'd10, 8'd0);
    set_port(1, 1'b1, 1'b0, 4'd11, 8'd0);
    a0c = 0; a1c = 0;
    for (int k = 1; k <= 20 && (a0c == 0 || a1c == 0); k++) begin
      @(negedge clk);
      if (ack0 && a0c == 0) begin a0c = k; req0 = 1'b0; end
      if (ack1 && a1c == 0) begin a1c = k; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check({nm, "_ack0_cycle"}, a0c, (first == 0) ? N + 1 : 2 * N + 3);
    check({nm, "_ack1_cycle"}, a1c, (first == 1) ? N + 1 : 2 * N + 3);
    check({nm, "_rdata0"}, rdata0, 8'h03);
    check({nm, "_rdata1"}, rdata1, 8'h02);
  endtask

  typedef struct {
    int p; logic w; logic [3:0] a; logic [7:0] d; logic [7:0] r0; logic [7:0] r1;
  } vec_t;

  // Transaction-level reference state for the random phase.
  logic [7:0] ref_mem [16];
  logic [7:0] m_r [2];
  logic       m_busy, m_we;
  int         m_g, m_port, m_last;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic       pend [2];

  initial begin
    vec_t tbl [6];
    int   got, acks, c, e;
    logic ok, acc, dn, a_p;
    logic [33:0] exp;

    tbl[0] = '{0, 1'b0, 4'd10, 8'h00, 8'h03, 8'h00};
    tbl[1] = '{1, 1'b1, 4'd12, 8'hA5, 8'h03, 8'h00};
    tbl[2] = '{1, 1'b0, 4'd12, 8'h00, 8'h03, 8'hA5};
    tbl[3] = '{1, 1'b0, 4'd11, 8'h00, 8'h03, 8'h02};
    tbl[4] = '{0, 1'b1, 4'd3,  8'h5A, 8'h03, 8'h02};
    tbl[5] = '{0, 1'b0, 4'd3,  8'h00, 8'h5A, 8'h02};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[10] = 8'h03;
    mem[11] = 8'h02;

    @(negedge clk);
    check("reset_outputs", outs, 34'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d_rdata0", i), rdata0, tbl[i].r0);
      check($sformatf("vec%0d_rdata1", i), rdata1, tbl[i].r1);
    end

    do_reset();
    tie_test("tie1", 0);
    tie_test("tie2", 0);
    do_access("solo0", 0, 1'b0, 4'd10, 8'h00);
    tie_test("tie3", 1);

    // Reset pulsed during a write's ACCESS.
    wait_idle();
    set_port(1, 1'b1, 1'b1, 4'd12, 8'h77);
    @(negedge clk);
    check("rst_pre_write", ram_write_enable, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_immediate", outs, 34'd0);
    set_port(1, 1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", outs, 34'd0);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acks += int'(ack0 | ack1);
    end
    check("rst_no_ack", acks, 0);
    check("rst_idle_rdata", {busy, rdata0, rdata1}, 17'd0);

    // Requester changes address/op after grant and drops req mid-ACCESS.
    wait_idle();
    set_port(0, 1'b1, 1'b0, 4'd10, 8'h00);
    ok = 1'b1; got = 0;
    for (int k = 1; k <= 12 && got == 0; k++) begin
      @(negedge clk);
      if (k <= N && (ram_address !== 4'd10 || !ram_read_enable || ram_write_enable)) ok = 1'b0;
      if (k == 1) begin addr0 = 4'd11; we0 = 1'b1; wdata0 = 8'hFF; end
      if (k == 2) req0 = 1'b0;
      if (ack0) got = k;
    end
    set_port(0, 1'b0, 1'b0, 4'd0, 8'd0);
    check("hold_addr", ok, 1'b1);
    check("hold_ack_cycle", got, N + 1);
    check("hold_rdata0", rdata0, 8'h03);
    check("hold_mem11", mem[11], 8'h02);

    // Random traffic against the transaction model.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    m_r[0] = 8'h00; m_r[1] = 8'h00;
    m_busy = 1'b0; m_last = 1; m_g = 0; m_port = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    c = 0;
    for (int it = 0; it < 500; it++) begin
      acc = m_busy && (c < m_g + N);
      dn  = m_busy && (c == m_g + N);
      exp = {dn && m_port == 0, dn && m_port == 1, m_r[0], m_r[1], acc ? m_addr : 4'd0,
             acc && m_we, acc && !m_we, (acc && m_we) ? m_wdata : 8'd0, acc && m_we, m_busy};
      check($sformatf("rand_cycle%0d", c), outs, exp);

      for (int p = 0; p < 2; p++) begin
        a_p = (p == 0) ? ack0 : ack1;
        if (pend[p] && a_p) begin
          pend[p] = 1'b0;
          if ($urandom_range(1) == 1) begin
            set_port(p, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
            pend[p] = 1'b1;
          end else begin
            set_port(p, 1'b0, 1'b0, 4'd0, 8'd0);
          end
        end else if (!pend[p]) begin
          if ($urandom_range(2) == 0) begin
            set_port(p, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
            pend[p] = 1'b1;
          end
        end else if (m_busy && m_port == p) begin
          if ($urandom_range(3) == 0) begin
            if (p == 0) begin we0 = ~we0; addr0 = 4'($urandom); wdata0 = 8'($urandom); end
            else        begin we1 = ~we1; addr1 = 4'($urandom); wdata1 = 8'($urandom); end
          end
          if ($urandom_range(7) == 0) begin
            if (p == 0) req0 = 1'b0;
            else        req1 = 1'b0;
          end
        end
      end

      e = c + 1;
      if (m_busy) begin
        if (e == m_g + N) begin
          if (!m_we) m_r[m_port] = ref_mem[m_addr];
        end else if (e == m_g + N + 1) begin
          m_busy = 1'b0;
        end
      end else if (req0 || req1) begin
        m_port  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
        m_last  = m_port;
        m_g     = e;
        m_busy  = 1'b1;
        m_we    = (m_port == 1) ? we1 : we0;
        m_addr  = (m_port == 1) ? addr1 : addr0;
        m_wdata = (m_port == 1) ? wdata1 : wdata0;
        if (m_we) ref_mem[m_addr] = m_wdata;
      end

      @(posedge clk);
      c++;
      @(negedge clk);
    end
    set_port(0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_port(1, 1'b0, 1'b0, 4'd0, 8'd0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, giving the number of cycles each RAM access is held (legal range 1..15).
REQ-002 SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0 / req1  in  1  access request from port 0 (instruction fetch) and port 1 (data); each is held until its ack.
- we0 / we1  in  1  1 = write, 0 = read; qualified by req.
- addr0 / addr1  in  4  word address.
- wdata0 / wdata1  in  8  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  8  last read result for that port.
- ram_address  out  4  address to the RAM.
- ram_write_enable  out  1  RAM write strobe.
- ram_read_enable  out  1  RAM read strobe.
- ram_wdata  out  8  data driven toward the RAM data bus.
- ram_drive  out  1  tristate enable for ram_wdata onto the shared bus.
- ram_rdata  in  8  RAM data bus, sampled on reads.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, with no other states.
REQ-004 IDLE: if any req is high, SHALL grant one port, latch its we/addr/wdata, load the counter with ACCESS_CYCLES, and enter ACCESS on the same edge; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL follow these rules:
- Only req1 high: grant port 1.
- Only req0 high: grant port 0.
- Both high: grant the port that was not granted last (round-robin).
- The last-grant register SHALL reset to port 1, so port 0 wins the first tie.
REQ-006 ACCESS SHALL last exactly ACCESS_CYCLES cycles.
- ram_address SHALL equal the latched address throughout.
- On a read, ram_read_enable SHALL be 1 and ram_write_enable 0.
- On a write, ram_write_enable, ram_drive and ram_wdata (= latched data) SHALL be active, and ram_read_enable SHALL be 0.
REQ-007 ram_read_enable and ram_write_enable SHALL never be high together; both SHALL be 0 in IDLE and DONE.
REQ-008 On the edge that ends the last ACCESS cycle of a read, the granted port's rdata SHALL capture ram_rdata.
- Write completion SHALL leave rdata unchanged.
- The other port's rdata SHALL never change.
REQ-009 DONE SHALL last one cycle with the granted port's ack = 1; the next state SHALL be IDLE unconditionally.
REQ-010 Latency: a request sampled in IDLE at edge 0 SHALL produce ack during cycle ACCESS_CYCLES+1; with the default, the ack is in the 3rd cycle after edge 0.
REQ-011 Requester-side changes to we/addr/wdata after the grant SHALL be ignored until the next grant.
- A req that drops during ACCESS SHALL NOT abort the access; its ack is still issued.
REQ-012 A req still high in the IDLE cycle after its own ack SHALL be treated as a new request (back-to-back accesses are allowed).
REQ-013 Throughput: one access per ACCESS_CYCLES+2 cycles; under continuous contention each port gets every other slot.
REQ-014 The counter SHALL be 4 bits wide and SHALL NOT wrap; ACCESS exits when it reaches 1.

Reset
REQ-015 While rst_n = 0, the block SHALL be in IDLE and every output SHALL be 0: ack0, ack1, rdata0, rdata1, ram_address, ram_write_enable, ram_read_enable, ram_wdata, ram_drive and busy.
REQ-016 Reset asserted mid-ACCESS SHALL immediately deassert all RAM strobes and suppress the ack.
- A RAM write interrupted this way is undefined; software reissues it.
REQ-017 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge with rst_n = 1.

Structure
REQ-018 Package ram_ctrl_pkg SHALL hold ADDR_W = 4, DATA_W = 8, the state enum (IDLE, ACCESS, DONE) and the port-index type.
REQ-019 The 2-way round-robin grant logic (request pair and last-grant in, one-hot grant out) SHALL be a separate sub-module, ram_rr_arbiter.
REQ-020 The tristate SHALL be outside this block; this block only produces ram_drive.

Verification
REQ-021 Benches SHALL cover these directed scenarios against a RAM model preloaded with address 10 = 8'h03 and address 11 = 8'h02:
- req0 read addr 10, ACCESS_CYCLES = 2 -> ack0 in 3rd cycle; rdata0 = 8'h03; rdata1 stays 8'h00.
- req1 write addr 12 data 8'hA5, then req1 read addr 12 -> write strobe held 2 cycles with ram_drive = 1; second ack gives rdata1 = 8'hA5.
- req0 and req1 rise in the same cycle (reads of addr 10 and 11) -> port 0 served first (rdata0 = 8'h03), then port 1 (rdata1 = 8'h02); the next tie goes to port 0 again only after port 1 has been served.
- rst_n pulsed low mid-ACCESS of a write -> all strobes go 0 immediately, no ack, state IDLE, rdata0 = rdata1 = 8'h00.
- addr0 changed from 10 to 11 during ACCESS -> ram_address stays 10 and rdata0 = 8'h03.
- Assertion throughout all scenarios: ram_read_enable and ram_write_enable are never both 1, and ack0 and ack1 are never both 1.
